pipe_result_collector: RTL and testbench

Downstream stage of the 3-stage arithmetic pipeline, which computes F = ((A+B)+(C−D))·D and has neither stall nor valid signalling. The block tracks issued operand sets through a valid shift chain matched to the pipeline latency and captures each F as it emerges into a small FIFO. It presents the results to the consumer with a valid/ready handshake. It also grants issue credit to the upstream source, so results are never lost when the consumer back-pressures.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/result_fifo.sv | 63 ++++++
 rtl/pipe_result_collector.sv | 104 ++++++++++
 tb/tb_pipe_result_collector.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the F = ((A+B)+(C-D))*D pipeline and its result collector.
package pipe_pkg;

    localparam int PIPE_N     = 10;  // data width of A/B/C/D and F
    localparam int PIPE_LAT   = 3;   // clock edges from operand sample to F sample
    localparam int FIFO_DEPTH = 4;   // result buffer entries (power of two, >= 2)
    localparam int RES_CNT_W  = 16;  // delivered-result counter width

    // Pointer/count width for a buffer of the given depth; one extra bit so
    // that a full buffer's count (== depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W = cnt_width(FIFO_DEPTH);

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding captured pipeline results until the consumer takes them.
module result_fifo
    import pipe_pkg::*;
#(
    parameter int W     = PIPE_N,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int CW   = cnt_width(DEPTH),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_push;

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop frees its slot before the push lands, so push-at-full is fine when paired with a pop.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage, pointers (wrapping at DEPTH) and occupancy count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr <= (r_wr_ptr == CW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == CW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_result_collector.sv
// Collects F from the non-stallable arithmetic pipeline, buffers it, and hands
// it to a valid/ready consumer while metering upstream issue with credits.
module pipe_result_collector
    import pipe_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int LAT   = PIPE_LAT,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_issue_valid,
    output logic                 o_issue_ready,
    input  logic [N-1:0]         i_f_in,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [N-1:0]         o_out_data,
    output logic                 o_drop_err,
    output logic [RES_CNT_W-1:0] o_result_cnt
);

    localparam int CW = cnt_width(DEPTH);
    localparam int IW = $clog2(LAT + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    logic [LAT-1:0]       r_vchain;
    logic                 r_drop_err;
    logic [RES_CNT_W-1:0] r_result_cnt;

    logic [IW-1:0]        w_inflight;
    logic [SW-1:0]        w_occupancy;
    logic                 w_issue_ready;
    logic                 w_issue;
    logic                 w_capture;
    logic                 w_pop;
    logic                 w_cap_drop;
    logic [CW-1:0]        w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    // Credit: every in-flight set will land in the FIFO, so reserve a slot for each.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + IW'(r_vchain[i]);
        end
        w_occupancy   = SW'(w_fifo_count) + SW'(w_inflight);
        w_issue_ready = (w_occupancy < SW'(DEPTH));
    end

    assign w_issue    = i_issue_valid & w_issue_ready;
    assign w_capture  = r_vchain[LAT-1];
    assign w_pop      = ~w_fifo_empty & i_out_ready;
    // Only reachable if the credit scheme is broken; the sample is lost.
    assign w_cap_drop = w_capture & w_fifo_full & ~w_pop;

    result_fifo #(
        .W     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_capture),
        .i_data  (i_f_in),
        .i_pop   (w_pop),
        .o_data  (o_out_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Valid chain mirroring the pipeline stages; bit LAT-1 marks F arriving this edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vchain <= '0;
        end else begin
            r_vchain <= (r_vchain << 1) | LAT'(w_issue);
        end
    end

    // Sticky loss flag: an uncredited issue or a capture that found no room.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_err <= 1'b0;
        end else if ((i_issue_valid && !w_issue_ready) || w_cap_drop) begin
            r_drop_err <= 1'b1;
        end
    end

    // Count of results handed to the consumer, free-running with wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result_cnt <= '0;
        end else if (w_pop) begin
            r_result_cnt <= r_result_cnt + 1'b1;
        end
    end

    assign o_issue_ready = w_issue_ready;
    assign o_out_valid   = ~w_fifo_empty;
    assign o_drop_err    = r_drop_err;
    assign o_result_cnt  = r_result_cnt;

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector driven by a behavioural model of the
// 3-stage F = ((A+B)+(C-D))*D pipeline.
module tb_pipe_result_collector;

    localparam int N   = 10;
    localparam int LAT = 3;

    logic          clk;
    logic          rst_n;
    logic          issue_valid;
    logic          issue_ready;
    logic [N-1:0]  f_in;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          drop_err;
    logic [15:0]   result_cnt;

    logic [N-1:0]  op_a, op_b, op_c, op_d;
    logic [N-1:0]  p1_ab, p1_cd, p1_d, p2_s, p2_d;

    int n_checks = 0;
    int n_errors = 0;
    int grants;
    int issued;
    int got;

    pipe_result_collector dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_issue_valid (issue_valid),
        .o_issue_ready (issue_ready),
        .i_f_in        (f_in),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_drop_err    (drop_err),
        .o_result_cnt  (result_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipeline model: operands sampled at edge k, F register valid after edge k+2,
    // so the collector samples it at edge k+3.
    always @(posedge clk) begin
        p1_ab <= op_a + op_b;
        p1_cd <= op_c - op_d;
        p1_d  <= op_d;
        p2_s  <= p1_ab + p1_cd;
        p2_d  <= p1_d;
        f_in  <= p2_s * p2_d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int a, input int b, input int c, input int d);
        op_a = N'(a);
        op_b = N'(b);
        op_c = N'(c);
        op_d = N'(d);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        set_ops(0, 0, 0, 0);
        repeat (2) tick();

        chk("rst_out_valid",   32'(out_valid),   0);
        chk("rst_out_data",    32'(out_data),    0);
        chk("rst_issue_ready", 32'(issue_ready), 1);
        chk("rst_drop_err",    32'(drop_err),    0);
        chk("rst_result_cnt",  32'(result_cnt),  0);

        // Single issue: (10+9)+(8-7)=20, *7 = 140
        rst_n = 1'b1;
        set_ops(10, 9, 8, 7);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        chk("single_ready_after_issue", 32'(issue_ready), 1);
        tick();
        tick();
        chk("single_not_yet_valid", 32'(out_valid), 0);
        tick();
        chk("single_valid",  32'(out_valid), 1);
        chk("single_data",   32'(out_data),  140);
        out_ready = 1'b1;
        tick();
        chk("single_cnt",     32'(result_cnt), 1);
        chk("single_drained", 32'(out_valid),  0);

        // Back-to-back: 140, (18+3)*2=42, (30-1)*6=174, (8-2)*7=42
        issue_valid = 1'b1;
        set_ops(10, 9, 8, 7);  tick();
        set_ops(10, 8, 5, 2);  tick();
        set_ops(20, 10, 5, 6); tick();
        set_ops(4, 4, 5, 7);   tick();
        issue_valid = 1'b0;
        chk("b2b_data0", 32'(out_data), 140);
        tick();
        chk("b2b_data1", 32'(out_data), 42);
        tick();
        chk("b2b_data2", 32'(out_data), 174);
        tick();
        chk("b2b_data3", 32'(out_data), 42);
        chk("b2b_valid3", 32'(out_valid), 1);
        tick();
        chk("b2b_empty",    32'(out_valid),  0);
        chk("b2b_cnt",      32'(result_cnt), 5);
        chk("b2b_drop_err", 32'(drop_err),   0);

        // Back-pressure: source honours credit; (k+1)+(0-1)=k, *1 = k
        out_ready = 1'b0;
        grants    = 0;
        for (int i = 0; i < 8; i++) begin
            issue_valid = issue_ready;
            set_ops(11 + grants, 1, 0, 1);
            if (issue_ready) grants++;
            tick();
        end
        issue_valid = 1'b0;
        chk("bp_grants",      32'(grants),      4);
        chk("bp_ready_low",   32'(issue_ready), 0);
        chk("bp_full_valid",  32'(out_valid),   1);
        chk("bp_head",        32'(out_data),    11);
        chk("bp_no_drop",     32'(drop_err),    0);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_data",   32'(out_data),    12);
        chk("bp_ready_back",  32'(issue_ready), 1);
        tick();
        chk("bp_pop2_data",   32'(out_data),    13);
        tick();
        chk("bp_pop3_data",   32'(out_data),    14);
        tick();
        chk("bp_empty",       32'(out_valid),   0);
        chk("bp_cnt",         32'(result_cnt),  9);

        // Modular result: (500+500)+(0-2)=998, *2 = 1996 mod 1024 = 972
        out_ready   = 1'b0;
        set_ops(500, 500, 0, 2);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        repeat (3) tick();
        chk("wrap_data", 32'(out_data), 972);
        out_ready = 1'b1;
        tick();
        chk("wrap_cnt", 32'(result_cnt), 10);

        // Ten results through a 4-deep buffer: pointers wrap, order preserved
        issued = 0;
        got    = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (issued < 10 && issue_ready) begin
                issue_valid = 1'b1;
                set_ops(100 + issued, 1, 0, 1);
                issued++;
            end else begin
                issue_valid = 1'b0;
            end
            tick();
            if (out_valid) begin
                chk("stream_data", 32'(out_data), 32'(100 + got));
                got++;
            end
        end
        issue_valid = 1'b0;
        tick();
        chk("stream_got",   32'(got),        10);
        chk("stream_cnt",   32'(result_cnt), 20);
        chk("stream_empty", 32'(out_valid),  0);

        // Uncredited issue: flagged, buffer and chain untouched
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ops(200 + i, 1, 0, 1);
            tick();
        end
        issue_valid = 1'b0;
        repeat (3) tick();
        chk("drop_pre_ready", 32'(issue_ready), 0);
        chk("drop_pre_err",   32'(drop_err),    0);
        set_ops(250, 1, 0, 1);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        chk("drop_err_set",  32'(drop_err),    1);
        chk("drop_head",     32'(out_data),    200);
        chk("drop_ready",    32'(issue_ready), 0);
        repeat (4) tick();
        chk("drop_ready_later", 32'(issue_ready), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drop_drain_data", 32'(out_data), 32'(200 + i));
            tick();
        end
        chk("drop_drain_empty", 32'(out_valid),  0);
        chk("drop_sticky",      32'(drop_err),   1);
        chk("drop_cnt",         32'(result_cnt), 24);

        // Async reset with 2 buffered and 2 in flight
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ops(300 + i, 1, 0, 1);
            tick();
        end
        issue_valid = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(out_valid),   1);
        chk("pre_rst_head",  32'(out_data),    300);
        chk("pre_rst_ready", 32'(issue_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid),   0);
        chk("async_rst_data",  32'(out_data),    0);
        chk("async_rst_ready", 32'(issue_ready), 1);
        chk("async_rst_drop",  32'(drop_err),    0);
        chk("async_rst_cnt",   32'(result_cnt),  0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            chk("post_rst_no_stale", 32'(out_valid), 0);
        end
        chk("post_rst_ready", 32'(issue_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
